// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - fixed-priority interrupt arbiter with claim/complete sequencing
//
// Purpose: synchronises NUM_SRC interrupt lines and latches their pending state
// (edge or level per source). It masks pending with ENABLE and presents the
// lowest-index candidate to the exception unit. It then tracks the ack (claim)
// and done (mret) handshake.
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   irq_src_i[NUM_SRC]    raw interrupt lines, active high
//   int_ack_i             exception unit took int_id_o (1-cycle pulse)
//   int_done_i            mret retired for the active interrupt (1-cycle pulse)
//   reg_we_i/addr/wdata   register write port, addr[3:2] selects the word
//   reg_rdata_o           combinational read data for reg_addr_i
//   int_req_o, int_id_o   registered request and id to the exception unit
module irq_arbiter #(
  parameter int NUM_SRC = 16,
  parameter int ID_BASE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               int_ack_i,
  input  logic               int_done_i,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               int_req_o,
  output logic [7:0]         int_id_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, hist_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic               req_q, req_d;
  logic [7:0]         id_q, id_d;
  logic [7:0]         active_id_q, active_id_d;
  logic [4:0]         win_q, win_d;

  logic [NUM_SRC-1:0] cand, rise, w1c_clr, ack_clr, wdata_src;
  logic [31:0]        cand_ext, win_mask;
  logic               arb_hit;
  logic [4:0]         arb_idx;
  logic               wr_enable, wr_edge, wr_pend;
  logic               unused_bits;

  assign wdata_src = reg_wdata_i[NUM_SRC-1:0];
  assign wr_enable = reg_we_i && (reg_addr_i[3:2] == 2'd0);
  assign wr_edge   = reg_we_i && (reg_addr_i[3:2] == 2'd1);
  assign wr_pend   = reg_we_i && (reg_addr_i[3:2] == 2'd2);

  assign cand     = pend_q & enable_q;
  assign cand_ext = 32'(cand);
  assign rise     = sync2_q & ~hist_q;
  assign w1c_clr  = wr_pend ? wdata_src : '0;
  assign win_mask = 32'd1 << win_q;

  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i, win_mask, cand_ext};

  // Lowest set index wins; scanning downward leaves the lowest hit last.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        arb_hit = 1'b1;
        arb_idx = 5'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    id_d        = id_q;
    active_id_d = active_id_q;
    win_d       = win_q;
    ack_clr     = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          req_d   = 1'b1;
          id_d    = 8'(ID_BASE) + {3'b000, arb_idx};
          win_d   = arb_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Ack takes priority over a withdraw seen in the same cycle.
        if (int_ack_i) begin
          req_d       = 1'b0;
          active_id_d = id_q;
          ack_clr     = win_mask[NUM_SRC-1:0];
          state_d     = S_ACTIVE;
        end else if (!cand_ext[win_q]) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (int_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edge bits: a fresh rise beats any clear in the same cycle.
  // Level bits simply track the synchronised line.
  always_comb begin
    pend_d   = (edge_q & ((pend_q & ~(ack_clr | w1c_clr)) | rise)) | (~edge_q & sync2_q);
    enable_d = wr_enable ? wdata_src : enable_q;
    edge_d   = wr_edge ? wdata_src : edge_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_q      <= '0;
      pend_q      <= '0;
      enable_q    <= '0;
      edge_q      <= '0;
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      id_q        <= '0;
      active_id_q <= '0;
      win_q       <= '0;
    end else begin
      sync1_q     <= irq_src_i;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      pend_q      <= pend_d;
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      state_q     <= state_d;
      req_q       <= req_d;
      id_q        <= id_d;
      active_id_q <= active_id_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    case (reg_addr_i[3:2])
      2'd0: reg_rdata_o = 32'(enable_q);
      2'd1: reg_rdata_o = 32'(edge_q);
      2'd2: reg_rdata_o = 32'(pend_q);
      2'd3: reg_rdata_o = {23'd0, (state_q != S_IDLE), active_id_q};
      default: reg_rdata_o = '0;
    endcase
  end

  assign int_req_o = req_q;
  assign int_id_o  = id_q;

endmodule
